// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives a combinational word-indexed ROM and
// registers {pc, instr} into a one-entry valid/ready output stage toward decode.
// Supports redirects, a level halt request, and a sticky fault on misaligned redirect
// targets or fetches beyond the end of the ROM.
module fetch_sequencer #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     IMEM_WORDS = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_instr_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic            fault_o
);

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt,
    StFault
  } state_e;

  localparam logic [XLEN-3:0] ImemLimit = (XLEN-2)'(IMEM_WORDS);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] if_pc_q;
  logic [XLEN-1:0] if_instr_q;
  logic            if_valid_q;
  logic            fault_q;

  logic            accept;
  logic            slot_free;
  logic            redir_misaligned;
  logic            pc_out_of_range;

  // Handshake and fetch-legality qualifiers; all derived from registered state or
  // inputs that only feed the next-state logic.
  always_comb begin
    accept           = if_valid_q & if_ready_i;
    slot_free        = ~if_valid_q | accept;
    redir_misaligned = |redirect_pc_i[1:0];
    // Also catches pc_q+4 wrapping past the top of the address space.
    pc_out_of_range  = (pc_q[XLEN-1:2] >= ImemLimit);
  end

  assign imem_addr_o = {2'b00, pc_q[XLEN-1:2]};
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_instr_o  = if_instr_q;
  assign fault_o     = fault_q;

  // Control FSM with the PC and the registered output stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot: begin
          state_q <= StRun;
        end

        StRun: begin
          if (redirect_valid_i) begin
            // Flush wins even over a same-cycle accept.
            if_valid_q <= 1'b0;
            if (redir_misaligned) begin
              state_q <= StFault;
              fault_q <= 1'b1;
            end else begin
              pc_q <= redirect_pc_i;
            end
          end else if (halt_i) begin
            state_q <= StHalt;
            if (accept) if_valid_q <= 1'b0;
          end else if (pc_out_of_range && slot_free) begin
            state_q    <= StFault;
            fault_q    <= 1'b1;
            if_valid_q <= 1'b0;
          end else if (slot_free) begin
            if_pc_q    <= pc_q;
            if_instr_q <= imem_instr_i;
            if_valid_q <= 1'b1;
            pc_q       <= pc_q + XLEN'(4);
          end
          // Otherwise stalled: hold the beat and the PC.
        end

        StHalt: begin
          if (redirect_valid_i) begin
            if_valid_q <= 1'b0;
            if (redir_misaligned) begin
              state_q <= StFault;
              fault_q <= 1'b1;
            end else begin
              pc_q <= redirect_pc_i;
            end
          end else begin
            if (accept) if_valid_q <= 1'b0;
            if (!halt_i) state_q <= StRun;
          end
        end

        StFault: begin
          // Terminal until reset; PC stays at the faulting address.
          fault_q    <= 1'b1;
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by random traffic,
// all compared each cycle against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

  localparam int unsigned Words = 32;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        halt_i = 1'b0;
  logic        if_valid_o;
  logic        if_ready_i = 1'b0;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        fault_o;

  fetch_sequencer #(
    .XLEN      (32),
    .RESET_PC  (32'h0),
    .IMEM_WORDS(Words)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .imem_addr_o     (imem_addr_o),
    .imem_instr_i    (imem_instr_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .halt_i          (halt_i),
    .if_valid_o      (if_valid_o),
    .if_ready_i      (if_ready_i),
    .if_pc_o         (if_pc_o),
    .if_instr_o      (if_instr_o),
    .fault_o         (fault_o)
  );

  always #5 clk_i = ~clk_i;

  // Combinational ROM; reads past the end return junk the DUT must never capture.
  logic [31:0] rom [Words];
  always_comb begin
    if (imem_addr_o < Words) imem_instr_i = rom[imem_addr_o[4:0]];
    else imem_instr_i = 32'hBAD0BAD0;
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0=boot, 1=run, 2=halt, 3=fault.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_opc;
  logic [31:0] m_oi;
  logic        m_v;
  logic        m_f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid"}, {31'b0, if_valid_o}, {31'b0, m_v});
    check({tag, "_pc"}, if_pc_o, m_opc);
    check({tag, "_instr"}, if_instr_o, m_oi);
    check({tag, "_fault"}, {31'b0, fault_o}, {31'b0, m_f});
    check({tag, "_addr"}, imem_addr_o, m_pc >> 2);
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 32'h0;
    m_opc  = '0;
    m_oi   = '0;
    m_v    = 1'b0;
    m_f    = 1'b0;
  endtask

  // Apply a redirect: flush, then either retarget or fault.
  task automatic model_redirect(input logic [31:0] rpc);
    m_v = 1'b0;
    if (rpc % 4 != 0) begin
      m_mode = 3;
      m_f    = 1'b1;
    end else begin
      m_pc = rpc;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input string tag, input logic rd, input logic [31:0] rpc,
                      input logic hlt, input logic rdy);
    logic acc;
    logic free;
    redirect_valid_i = rd;
    redirect_pc_i    = rpc;
    halt_i           = hlt;
    if_ready_i       = rdy;
    acc  = m_v && rdy;
    free = !m_v || acc;
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (rd) model_redirect(rpc);
        else if (hlt) begin
          m_mode = 2;
          if (acc) m_v = 1'b0;
        end else if (m_pc / 4 >= Words) begin
          if (free) begin
            m_mode = 3;
            m_f    = 1'b1;
            m_v    = 1'b0;
          end
        end else if (free) begin
          m_opc = m_pc;
          m_oi  = rom[m_pc / 4];
          m_v   = 1'b1;
          m_pc  = m_pc + 4;
        end
      end
      2: begin
        if (rd) model_redirect(rpc);
        else begin
          if (acc) m_v = 1'b0;
          if (!hlt) m_mode = 1;
        end
      end
      default: ;
    endcase
    @(posedge clk_i);
    #1;
    check_all(tag);
  endtask

  // Assert reset between edges, confirm outputs clear at once, release after one edge.
  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    redirect_valid_i = 1'b0;
    halt_i = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < Words; i++) rom[i] = $urandom;
    rom[0] = 32'h03C00093;
    rom[1] = 32'h02102FA3;
    model_reset();
    #2;

    // 1: boot latency and first two beats.
    do_reset("t1_rst");
    step("t1_e1", 0, 0, 0, 1);
    step("t1_e2", 0, 0, 0, 1);
    check("t1_pc0", if_pc_o, 32'h0);
    check("t1_in0", if_instr_o, 32'h03C00093);
    step("t1_e3", 0, 0, 0, 1);
    check("t1_pc1", if_pc_o, 32'h4);
    check("t1_in1", if_instr_o, 32'h02102FA3);

    // 2: stall holds the beat and PC, release continues at 0x8.
    for (int i = 0; i < 3; i++) step("t2_stall", 0, 0, 0, 0);
    check("t2_hold_pc", if_pc_o, 32'h4);
    check("t2_pcq", imem_addr_o, 32'h2);
    step("t2_rel", 0, 0, 0, 1);
    check("t2_next", if_pc_o, 32'h8);

    // 3: redirect while stalled flushes, then fetches the target.
    step("t3_stall", 0, 0, 0, 0);
    step("t3_redir", 1, 32'h10, 0, 0);
    check("t3_flush", {31'b0, if_valid_o}, 32'h0);
    step("t3_tgt", 0, 0, 0, 1);
    check("t3_tpc", if_pc_o, 32'h10);
    check("t3_tin", if_instr_o, rom[4]);

    // 4: misaligned redirect is a sticky fault.
    step("t4_mis", 1, 32'h6, 0, 1);
    check("t4_fault", {31'b0, fault_o}, 32'h1);
    for (int i = 0; i < 3; i++) step("t4_stick", 0, 32'h20, 0, 1);

    // 5: free-run to the last ROM word, then range fault at 0x80.
    do_reset("t5_rst");
    for (int i = 0; i < 33; i++) step("t5_run", 0, 0, 0, 1);
    check("t5_last", if_pc_o, 32'h7C);
    step("t5_oor", 0, 0, 0, 1);
    check("t5_fault", {31'b0, fault_o}, 32'h1);
    check("t5_pcq", imem_addr_o, 32'h20);

    // 6: halt drains the held beat, resume at held PC, reset mid-halt.
    do_reset("t6_rst");
    step("t6_boot", 0, 0, 0, 1);
    step("t6_f0", 0, 0, 0, 0);
    step("t6_h0", 0, 0, 1, 0);
    step("t6_h1", 0, 0, 1, 0);
    step("t6_h2", 0, 0, 1, 1);
    step("t6_h3", 0, 0, 1, 1);
    check("t6_drain", {31'b0, if_valid_o}, 32'h0);
    step("t6_unh", 0, 0, 0, 1);
    step("t6_res", 0, 0, 0, 0);
    check("t6_respc", if_pc_o, 32'h4);
    step("t6_h4", 0, 0, 1, 0);
    step("t6_h5", 0, 0, 1, 0);
    do_reset("t6_midrst");
    check("t6_zero", {if_valid_o, fault_o, if_pc_o[29:0]} | {2'b0, if_instr_o[29:0]}, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic        rd;
      logic [31:0] rpc;
      if (m_f || $urandom_range(0, 99) == 0) do_reset("rnd_rst");
      rd  = ($urandom_range(0, 9) == 0);
      rpc = 32'($urandom_range(0, 35)) << 2;
      if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      step("rnd", rd, rpc, $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
